// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state codes, opcodes, mux encodings and control word shared by the multicycle control FSM
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCS_ALU     = 2'b00;
  localparam logic [1:0] PCS_ALUOUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP    = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: state to control word decoder; state_i, mem_ready_i (FETCH strobe gating) in, ctrl_o out
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCS_ALU;
      end
      S_DECODE: ctrl_o.alu_src_b = ALUB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_ADDI_WB: ctrl_o.reg_write = 1'b1;
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM; clk, rst (async low), instr_op, mem_ready in; datapath strobes, state_out, instr_count, illegal_op out
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           instr_op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state_out,
  output logic [WORD_SIZE-1:0] instr_count,
  output logic                 illegal_op
);
  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;
  ctrl_t                cw;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (instr_op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      illegal_d = 1'b1;
        endcase
      S_MEM_ADDR:  state_d = instr_op == OP_SW ? S_MEM_WRITE : instr_op == OP_LW ? S_MEM_READ : S_FETCH;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end
  assign retire  = state_q inside {S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP} ||
                   (state_q == S_MEM_WRITE && mem_ready);
  assign count_d = count_q + WORD_SIZE'(retire);
  mc_output_decode u_dec (
    .state_i    (state_q),
    .mem_ready_i(mem_ready),
    .ctrl_o     (cw)
  );
  always_comb begin
    pc_write      = cw.pc_write;
    pc_write_cond = cw.pc_write_cond;
    i_or_d        = cw.i_or_d;
    mem_read      = cw.mem_read;
    mem_write     = cw.mem_write;
    ir_write      = cw.ir_write;
    mem_to_reg    = cw.mem_to_reg;
    reg_dst       = cw.reg_dst;
    reg_write     = cw.reg_write;
    alu_src_a     = cw.alu_src_a;
    alu_src_b     = cw.alu_src_b;
    alu_op        = cw.alu_op;
    pc_source     = cw.pc_source;
    state_out     = state_q;
    instr_count   = count_q;
    illegal_op    = illegal_q;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven scoreboard bench for multicycle_control
module tb_multicycle_control;
  localparam int W = 8;
  logic clk = 1'b0, rst, mem_ready;
  logic [5:0] instr_op;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_out;
  logic [W-1:0] instr_count;
  logic illegal_op;
  logic [15:0] act_ctl;
  typedef struct packed {
    logic [3:0]   st;
    logic [15:0]  ctl;
    logic [W-1:0] cnt;
    logic         ill;
  } rec_t;
  typedef struct {
    logic [5:0] op;
    int         len;
    logic [3:0] seq[6];
    logic       ret;
    logic       bad;
  } vec_t;
  rec_t sb[$];
  vec_t tbl[9];
  logic [W-1:0] cnt;
  logic ill;
  int nvec = 0, nerr = 0;
  multicycle_control #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_out(state_out), .instr_count(instr_count),
    .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic mr);
    case (s)
      4'd0:        return {mr, 3'b001, 1'b0, mr, 4'b0000, 2'b01, 4'b0000};
      4'd1:        return 16'b0000000000_110000;
      4'd2, 4'd10: return 16'b0000000001_100000;
      4'd3:        return 16'b0011000000_000000;
      4'd4:        return 16'b0000001010_000000;
      4'd5:        return 16'b0010100000_000000;
      4'd6:        return 16'b0000000001_001000;
      4'd7:        return 16'b0000000110_000000;
      4'd8:        return 16'b0100000001_000101;
      4'd9:        return 16'b1000000000_000010;
      4'd11:       return 16'b0000000010_000000;
      default:     return 16'h0000;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step(input logic mr, input logic [5:0] op, input logic [3:0] st);
    rec_t e;
    mem_ready = mr;
    instr_op = op;
    sb.push_back('{st, exp_ctl(st, mr), cnt, ill});
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("state%0d", st), 32'({state_out, act_ctl, instr_count, illegal_op}), 32'(e));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{6'b100011, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 1'b1, 1'b0};
    tbl[1] = '{6'b101011, 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 1'b1, 1'b0};
    tbl[2] = '{6'b000000, 4, '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 1'b1, 1'b0};
    tbl[3] = '{6'b000100, 3, '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
    tbl[4] = '{6'b000010, 3, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
    tbl[5] = '{6'b111111, 2, '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1};
    tbl[6] = '{6'b001000, 4, '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0}, 1'b1, 1'b0};
    tbl[7] = '{6'b010101, 2, '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1};
    tbl[8] = '{6'b100011, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 1'b1, 1'b0};
    cnt = '0;
    ill = 1'b0;
    rst = 1'b0;
    mem_ready = 1'b1;
    instr_op = 6'b0;
    #1;
    step(1'b1, 6'b100011, 4'd0);
    step(1'b0, 6'b100011, 4'd0);
    rst = 1'b1;
    step(1'b0, 6'b100011, 4'd0);
    step(1'b0, 6'b100011, 4'd0);
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < tbl[v].len; i++) step(1'b1, tbl[v].op, tbl[v].seq[i]);
      cnt = cnt + W'(tbl[v].ret);
      if (tbl[v].bad) ill = 1'b1;
    end
    step(1'b1, 6'b101011, 4'd0);
    step(1'b1, 6'b101011, 4'd1);
    step(1'b1, 6'b101011, 4'd2);
    repeat (3) step(1'b0, 6'b101011, 4'd5);
    step(1'b1, 6'b101011, 4'd5);
    cnt = cnt + 1'b1;
    step(1'b1, 6'b100011, 4'd0);
    step(1'b1, 6'b100011, 4'd1);
    step(1'b1, 6'b100011, 4'd2);
    repeat (2) step(1'b0, 6'b100011, 4'd3);
    step(1'b1, 6'b100011, 4'd3);
    step(1'b1, 6'b100011, 4'd4);
    cnt = cnt + 1'b1;
    step(1'b1, 6'b000000, 4'd0);
    step(1'b1, 6'b000000, 4'd1);
    sb.push_back('{4'd6, exp_ctl(4'd6, 1'b1), cnt, ill});
    @(negedge clk);
    chk("rtype_exec", 32'({state_out, act_ctl, instr_count, illegal_op}), 32'(sb.pop_front()));
    #2 rst = 1'b0;
    cnt = '0;
    ill = 1'b0;
    #1;
    chk("async_rst", 32'({state_out, instr_count, illegal_op}), 32'({4'd0, cnt, ill}));
    chk("rst_no_rw", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'({state_out, reg_write, instr_count}), 32'({4'd0, 1'b0, cnt}));
    rst = 1'b1;
    step(1'b0, 6'b000010, 4'd0);
    repeat (255) begin
      step(1'b1, 6'b000010, 4'd0);
      step(1'b1, 6'b000010, 4'd1);
      step(1'b1, 6'b000010, 4'd9);
      cnt = cnt + 1'b1;
    end
    chk("pre_wrap", 32'(instr_count), 32'(cnt));
    step(1'b1, 6'b000010, 4'd0);
    step(1'b1, 6'b000010, 4'd1);
    step(1'b1, 6'b000010, 4'd9);
    cnt = cnt + 1'b1;
    step(1'b0, 6'b000010, 4'd0);
    chk("wrap", 32'(instr_count), 32'(cnt));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
